// File: rtl/beta_alu.sv
// Beta-style ALU: arithmetic, compare, boolean and shift ops.
// Result and Z/N/V flags are registered, one cycle after issue.
module beta_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       ALUFN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam int M = WIDTH - 1;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100001;
  localparam logic [5:0] OP_EQ   = 6'b100100;
  localparam logic [5:0] OP_LT   = 6'b100101;
  localparam logic [5:0] OP_LE   = 6'b100110;
  localparam logic [5:0] OP_AND  = 6'b101000;
  localparam logic [5:0] OP_OR   = 6'b101001;
  localparam logic [5:0] OP_XOR  = 6'b101010;
  localparam logic [5:0] OP_XNOR = 6'b101011;
  localparam logic [5:0] OP_SHL  = 6'b101100;
  localparam logic [5:0] OP_SHR  = 6'b101101;
  localparam logic [5:0] OP_SRA  = 6'b101110;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_sh;
  logic             w_vadd;
  logic             w_vsub;
  logic             w_eq;
  logic             w_lt;
  logic [WIDTH-1:0] w_y;
  logic             w_v;

  logic [WIDTH-1:0] r_y;
  logic             r_z;
  logic             r_n;
  logic             r_v;

  assign w_sum  = A + B;
  assign w_diff = A - B;
  assign w_sh   = B[SHW-1:0];
  assign w_vadd = (A[M] == B[M]) && (w_sum[M] != A[M]);
  assign w_vsub = (A[M] != B[M]) && (w_diff[M] != A[M]);
  assign w_eq   = (A == B);
  // signed less-than from sign and overflow of A-B, so it never wraps
  assign w_lt   = w_diff[M] ^ w_vsub;

  always_comb begin
    w_y = '0;
    w_v = 1'b0;
    case (ALUFN)
      OP_ADD: begin
        w_y = w_sum;
        w_v = w_vadd;
      end
      OP_SUB: begin
        w_y = w_diff;
        w_v = w_vsub;
      end
      OP_EQ:   w_y = {{M{1'b0}}, w_eq};
      OP_LT:   w_y = {{M{1'b0}}, w_lt};
      OP_LE:   w_y = {{M{1'b0}}, w_lt | w_eq};
      OP_AND:  w_y = A & B;
      OP_OR:   w_y = A | B;
      OP_XOR:  w_y = A ^ B;
      OP_XNOR: w_y = ~(A ^ B);
      OP_SHL:  w_y = A << w_sh;
      OP_SHR:  w_y = A >> w_sh;
      OP_SRA:  w_y = $signed(A) >>> w_sh;
      default: begin
        w_y = '0;
        w_v = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y <= '0;
      r_z <= 1'b1;
      r_n <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_y <= w_y;
      r_z <= (w_y == '0);
      r_n <= w_y[M];
      r_v <= w_v;
    end
  end

  assign Y = r_y;
  assign Z = r_z;
  assign N = r_n;
  assign V = r_v;

endmodule

// File: tb/tb_beta_alu.sv
// Bench for beta_alu: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model.
module tb_beta_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ALUFN;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Y;
  logic        Z;
  logic        N;
  logic        V;

  int checks = 0;
  int errors = 0;

  beta_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ALUFN(ALUFN),
    .A(A), .B(B), .Y(Y), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain signed/unsigned arithmetic
  function automatic void model(
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        v
  );
    longint sa, sb, s;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    y = 32'd0;
    v = 1'b0;
    case (op)
      6'b100000: begin
        s = sa + sb;
        y = a + b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'b100001: begin
        s = sa - sb;
        y = a - b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'b100100: y = (a == b) ? 32'd1 : 32'd0;
      6'b100101: y = (sa < sb) ? 32'd1 : 32'd0;
      6'b100110: y = (sa <= sb) ? 32'd1 : 32'd0;
      6'b101000: y = a & b;
      6'b101001: y = a | b;
      6'b101010: y = a ^ b;
      6'b101011: y = ~(a ^ b);
      6'b101100: y = a << sh;
      6'b101101: y = a >> sh;
      6'b101110: y = $signed(a) >>> sh;
      default: y = 32'd0;
    endcase
  endfunction

  logic [31:0] exp_y;
  logic        exp_z, exp_n, exp_v;
  logic        exp_ok = 1'b0;

  always @(posedge clk) begin
    logic [31:0] my;
    logic        mv;
    model(ALUFN, A, B, my, mv);
    if (reset) begin
      exp_y <= 32'd0; exp_z <= 1'b1;
      exp_n <= 1'b0;  exp_v <= 1'b0;
    end else begin
      exp_y <= my; exp_z <= (my == 32'd0);
      exp_n <= my[31]; exp_v <= mv;
    end
    exp_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_ok) begin
      checks++;
      if (Y !== exp_y || Z !== exp_z || N !== exp_n || V !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got Y=%h Z%b N%b V%b want Y=%h Z%b N%b V%b",
                 $time, Y, Z, N, V, exp_y, exp_z, exp_n, exp_v);
      end
    end
  end

  task automatic chk(
    input string       name,
    input logic        rst,
    input logic [5:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] ey,
    input logic        ez,
    input logic        en,
    input logic        ev
  );
    @(negedge clk);
    reset = rst; ALUFN = op; A = a; B = b;
    @(posedge clk);
    #1;
    checks++;
    if (Y !== ey || Z !== ez || N !== en || V !== ev) begin
      errors++;
      $display("FAIL %s got Y=%h Z%b N%b V%b want Y=%h Z%b N%b V%b",
               name, Y, Z, N, V, ey, ez, en, ev);
    end
  endtask

  initial begin
    reset = 1'b1; ALUFN = 6'b100000; A = 32'd15; B = 32'd13;
    chk("reset", 1, 6'b100000, 15, 13, 32'd0, 1, 0, 0);
    chk("eq_ne", 0, 6'b100100, 15, 13, 32'd0, 1, 0, 0);
    chk("eq_eq", 0, 6'b100100, 13, 13, 32'd1, 0, 0, 0);
    chk("lt_gt", 0, 6'b100101, 15, 13, 32'd0, 1, 0, 0);
    chk("lt_eq", 0, 6'b100101, 13, 13, 32'd0, 1, 0, 0);
    chk("lt_lt", 0, 6'b100101, 13, 15, 32'd1, 0, 0, 0);
    chk("le_gt", 0, 6'b100110, 15, 13, 32'd0, 1, 0, 0);
    chk("le_eq", 0, 6'b100110, 13, 13, 32'd1, 0, 0, 0);
    chk("le_lt", 0, 6'b100110, 13, 15, 32'd1, 0, 0, 0);
    chk("lt_sgn", 0, 6'b100101, 32'hFFFFFFFF, 1, 32'd1, 0, 0, 0);
    chk("lt_ovf", 0, 6'b100101, 32'h7FFFFFFF, 32'h80000000,
        32'd0, 1, 0, 0);
    chk("add", 0, 6'b100000, 15, 13, 32'd28, 0, 0, 0);
    chk("sub", 0, 6'b100001, 15, 13, 32'd2, 0, 0, 0);
    chk("sub_z", 0, 6'b100001, 13, 13, 32'd0, 1, 0, 0);
    chk("sub_n", 0, 6'b100001, 13, 15, 32'hFFFFFFFE, 0, 1, 0);
    chk("add_v", 0, 6'b100000, 32'h7FFFFFFF, 1,
        32'h80000000, 0, 1, 1);
    chk("sub_v", 0, 6'b100001, 32'h80000000, 1,
        32'h7FFFFFFF, 0, 0, 1);
    chk("and", 0, 6'b101000, 15, 13, 32'd13, 0, 0, 0);
    chk("or", 0, 6'b101001, 15, 13, 32'd15, 0, 0, 0);
    chk("xor", 0, 6'b101010, 15, 13, 32'd2, 0, 0, 0);
    chk("xnor", 0, 6'b101011, 15, 13, 32'hFFFFFFFD, 0, 1, 0);
    chk("shl", 0, 6'b101100, 15, 4, 32'd240, 0, 0, 0);
    chk("shr", 0, 6'b101101, 15, 4, 32'd0, 1, 0, 0);
    chk("sra", 0, 6'b101110, 32'hFFFFFFF0, 4,
        32'hFFFFFFFF, 0, 1, 0);
    chk("shl_hi", 0, 6'b101100, 1, 32'h24, 32'd16, 0, 0, 0);
    chk("shl_0", 0, 6'b101100, 32'h89ABCDEF, 32'h40,
        32'h89ABCDEF, 0, 1, 0);
    chk("b2b_add", 0, 6'b100000, 100, 23, 32'd123, 0, 0, 0);
    chk("b2b_sub", 0, 6'b100001, 100, 23, 32'd77, 0, 0, 0);
    chk("rst_mid", 1, 6'b100000, 15, 13, 32'd0, 1, 0, 0);
    chk("post_rst", 0, 6'b101001, 32'hF0, 32'h0F, 32'hFF, 0, 0, 0);
    chk("illegal", 0, 6'b000000, 15, 13, 32'd0, 1, 0, 0);
    chk("ill_hi", 0, 6'b111111, 32'hFFFFFFFF, 13, 32'd0, 1, 0, 0);
    // a pseudo-random sweep checked only by the model process
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 31) == 0);
      ALUFN = 6'(($urandom_range(0, 3) == 0) ? $urandom
                 : (32'h20 | $urandom_range(0, 15)));
      A = $urandom;
      B = ($urandom_range(0, 3) == 0) ? A : $urandom;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
